texture_loader: RTL
===================

TEXTURE_LOADER -- requirements
Module: texture_loader

Interface
REQ-001 Parameter CHANNEL_BITS, default 2, SHALL set bits per colour channel; texel width is CHANNEL_BITS*3.
REQ-002 Parameter TEX_WORDS, default 8192, SHALL set texels per wall texture (2 sides x 64 cols x 64 rows).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  stream byte present.
REQ-006 in_data  input  8  stream byte.
REQ-007 in_ready  output  1  loader accepts in_data this cycle.
REQ-008 abort  input  1  synchronous cancel of a load in progress.
REQ-009 wr_en  output  1  texture memory write strobe, one texel per cycle.
REQ-010 wr_addr  output  15  {slot[1:0], index[12:0]}; slot = wtid-1; index = {~side,col,row}, row fastest.
REQ-011 wr_data  output  CHANNEL_BITS*3  texel value (low bits of the accepted byte).
REQ-012 busy  output  1  high in LOAD state.
REQ-013 done  output  1  one-cycle pulse when a full texture has been written.
REQ-014 err  output  1  sticky: last header was invalid.

Function
REQ-015 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both high.
REQ-016 States SHALL be IDLE, LOAD, DONE; encodings defined in the shared header.
REQ-017 IDLE: in_ready=1; an accepted byte is a header; a valid header is upper nibble 0xA with low 2 bits (wtid) in 1..3.
REQ-018 Valid header SHALL latch slot=wtid-1, clear index to 0, clear err, and enter LOAD next cycle.
REQ-019 Invalid header (wrong nibble or wtid=0) SHALL set err, perform no write, and remain in IDLE.
REQ-020 LOAD: in_ready = ~abort; each accepted byte SHALL produce wr_en=1 on the following cycle with wr_addr={slot,index} and wr_data=in_data[CHANNEL_BITS*3-1:0]; then index increments.
REQ-021 Write latency SHALL be exactly one cycle from acceptance; wr_en, wr_addr, and wr_data are registered.
REQ-022 Cycles without acceptance in LOAD SHALL leave wr_en=0 and index unchanged; no bubbles are inserted beyond the stream's own.
REQ-023 Acceptance of the byte at index TEX_WORDS-1 SHALL move to DONE; index SHALL NOT wrap into a second texture.
REQ-024 DONE: in_ready=0, done=1 for exactly one cycle (coinciding with the final wr_en), then IDLE.
REQ-025 abort in LOAD SHALL return to IDLE next cycle with no done pulse; the byte offered in the abort cycle is not accepted; earlier writes are not undone.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 abort and in_valid in the same LOAD cycle: abort wins (REQ-025).
REQ-028 busy SHALL equal (state==LOAD).

Reset
REQ-029 reset_n low SHALL asynchronously force state=IDLE, index=0, slot=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0; in_ready SHALL be 0 while reset_n is low and 1 in the first cycle after release.
REQ-030 Reset during LOAD SHALL abandon the load with no done pulse; the next header starts fresh at index 0.

Structure
REQ-031 A shared define header SHALL hold TEX_WORDS, the header magic nibble 0xA, and the state encodings, for reuse by the texture memory and testbench.
REQ-032 No sub-module is required; the index counter and FSM are inline in texture_loader.

Verification
REQ-033 Reset release, send 0xA2 then 8192 bytes 0x00..0xFF repeating -> 8192 writes at wr_addr 0x2000..0x3FFF, wr_data = byte & 0x3F, done pulses once, busy falls.
REQ-034 Send 0xA0, then 0x53 -> err=1 after each, no wr_en, state stays IDLE; then 0xA1 -> err cleared, busy=1.
REQ-035 Header 0xA3, 100 bytes with in_valid toggled randomly -> exactly 100 writes at 0x4000..0x4063, each one cycle after its handshake.
REQ-036 Header 0xA1, 50 bytes, abort held with in_valid=1 -> in_ready=0 in that cycle, 50 writes only, no done, IDLE next cycle; new 0xA1 restarts at wr_addr 0x0000.
REQ-037 reset_n pulsed low mid-LOAD at index 300 -> all outputs 0 immediately (asynchronously), no done; reload 0xA2 starts at 0x2000.
REQ-038 Final byte of a load with in_valid held high continuing -> in_ready=0 in DONE, the following byte is accepted in IDLE as a header.

Source files
------------

// File: rtl/texture_loader_pkg.sv
// Shared constants for the texture loader, the texture memory and the bench.
//   TEX_WORDS  : texels per wall texture (2 sides x 64 cols x 64 rows)
//   HDR_MAGIC  : upper nibble that marks a valid header byte
//   state_e    : loader FSM encodings
package texture_loader_pkg;

  localparam int TEX_WORDS  = 8192;
  localparam int INDEX_BITS = 13;
  localparam int SLOT_BITS  = 2;
  localparam int ADDR_BITS  = SLOT_BITS + INDEX_BITS;

  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Valid header: magic upper nibble and a non-zero wall texture id in bits [1:0].
  function automatic logic hdr_valid(input logic [7:0] b);
    return (b[7:4] == HDR_MAGIC) && (b[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/texture_loader_if.sv
// Byte stream in / texel write out bundle of the texture loader.
//   in_valid, in_data, in_ready : byte stream handshake (producer -> loader)
//   wr_en, wr_addr, wr_data     : texture memory write port (loader -> memory)
// master = stream producer / memory side, slave = loader.
interface texture_loader_if #(
  parameter int CHANNEL_BITS = 2
);
  import texture_loader_pkg::*;

  logic                      in_valid;
  logic [7:0]                in_data;
  logic                      in_ready;
  logic                      wr_en;
  logic [ADDR_BITS-1:0]      wr_addr;
  logic [CHANNEL_BITS*3-1:0] wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/texture_loader.sv
// Texture loader: parses a header byte (0xA? with wall texture id 1..3) and
// streams the following TEX_WORDS bytes into texture memory, one texel per
// accepted byte, one cycle after acceptance.
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : stream handshake + memory write port (slave side)
//   abort    : cancels a load in progress (ignored outside LOAD)
//   busy     : high while loading texels
//   done     : one-cycle pulse alongside the final texel write
//   err      : sticky, last header byte was invalid
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a header byte
// LOAD    | accepting texel bytes, writing one texel per accepted byte
// DONE    | final texel being written, stream stalled for one cycle
module texture_loader
  import texture_loader_pkg::*;
#(
  parameter int CHANNEL_BITS = 2,
  parameter int TEX_WORDS    = texture_loader_pkg::TEX_WORDS
) (
  input  logic             clk,
  input  logic             reset_n,
  texture_loader_if.slave  bus,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TEXEL_BITS = CHANNEL_BITS * 3;
  localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(TEX_WORDS - 1);

  state_e                  state_q,   state_d;
  logic [INDEX_BITS-1:0]   index_q,   index_d;
  logic [SLOT_BITS-1:0]    slot_q,    slot_d;
  logic                    wr_en_q,   wr_en_d;
  logic [ADDR_BITS-1:0]    wr_addr_q, wr_addr_d;
  logic [TEXEL_BITS-1:0]   wr_data_q, wr_data_d;
  logic                    done_q,    done_d;
  logic                    err_q,     err_d;
  logic                    in_ready;
  logic                    accept;

  always_comb begin
    // reset_n gating keeps in_ready low for the whole reset window
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = reset_n;
      ST_LOAD: in_ready = reset_n & ~abort;
      default: in_ready = 1'b0;
    endcase
    accept = bus.in_valid & in_ready;

    state_d   = state_q;
    index_d   = index_q;
    slot_d    = slot_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hdr_valid(bus.in_data)) begin
            slot_d  = bus.in_data[1:0] - 2'd1;
            index_d = '0;
            err_d   = 1'b0;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {slot_q, index_q};
          wr_data_d = bus.in_data[TEXEL_BITS-1:0];
          index_d   = index_q + 1'b1;
          // done is raised together with the final write, so it lands in DONE
          if (index_q == LAST_INDEX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      slot_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      slot_q    <= slot_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state_q == ST_LOAD);
  assign done         = done_q;
  assign err          = err_q;

endmodule
